// File: rtl/perf_mon_pkg.sv
// Shared types and constants for the stream performance monitor.
// Optional stall counting is enabled by defining PERF_MON_STALL_COUNT_EN.
package perf_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_STOP  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;

   localparam int OFF_BEATS  = 0;
   localparam int OFF_PKTS   = 1;
   localparam int OFF_STALLS = 2;
   localparam int OFF_OVF    = 3;
   localparam int STRIDE     = 4;

endpackage

// File: rtl/perf_channel_counter.sv
// Per-channel live counters, sticky overflow bits and shadow copies.
// Stall counting is present only when PERF_MON_STALL_COUNT_EN is defined.
module perf_channel_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 aclk,
   input  logic                 resetn,
   input  logic                 i_beat,
   input  logic                 i_pkt,
`ifdef PERF_MON_STALL_COUNT_EN
   input  logic                 i_stall,
`endif
   input  logic                 i_count_en,
   input  logic                 i_start,
   input  logic                 i_clear,
   input  logic                 i_snap,
   input  logic                 i_restart,
   output logic [CNT_WIDTH-1:0] o_beats,
   output logic [CNT_WIDTH-1:0] o_pkts,
   output logic [CNT_WIDTH-1:0] o_stalls,
   output logic [2:0]           o_ovf
);

   logic [CNT_WIDTH-1:0] r_beats, r_pkts, r_sh_beats, r_sh_pkts;
   logic [CNT_WIDTH-1:0] w_beats_nxt, w_pkts_nxt;
   logic [1:0]           r_ovf, r_sh_ovf, w_ovf_nxt;
   logic                 w_beat_ev, w_pkt_ev;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic ev);
      if (ev && (v != '1)) return v + 1'b1;
      return v;
   endfunction

   assign w_beat_ev   = i_count_en & i_beat;
   assign w_pkt_ev    = i_count_en & i_pkt;
   assign w_beats_nxt = sat_inc(r_beats, w_beat_ev);
   assign w_pkts_nxt  = sat_inc(r_pkts, w_pkt_ev);
   assign w_ovf_nxt   = r_ovf | {w_pkt_ev & (r_pkts == '1), w_beat_ev & (r_beats == '1)};

   // Live counters: snapshot values include the current cycle's event.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_beats <= '0;
         r_pkts  <= '0;
         r_ovf   <= '0;
      end else if (i_clear || i_start) begin
         r_beats <= '0;
         r_pkts  <= '0;
         r_ovf   <= '0;
      end else if (i_snap && i_restart) begin
         r_beats <= '0;
         r_pkts  <= '0;
         r_ovf   <= w_ovf_nxt;
      end else begin
         r_beats <= w_beats_nxt;
         r_pkts  <= w_pkts_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   // Shadow copies, loaded on a snapshot and zeroed by clear.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_sh_beats <= '0;
         r_sh_pkts  <= '0;
         r_sh_ovf   <= '0;
      end else if (i_clear) begin
         r_sh_beats <= '0;
         r_sh_pkts  <= '0;
         r_sh_ovf   <= '0;
      end else if (i_snap) begin
         r_sh_beats <= w_beats_nxt;
         r_sh_pkts  <= w_pkts_nxt;
         r_sh_ovf   <= w_ovf_nxt;
      end
   end

   assign o_beats = r_sh_beats;
   assign o_pkts  = r_sh_pkts;

`ifdef PERF_MON_STALL_COUNT_EN
   logic [CNT_WIDTH-1:0] r_stalls, r_sh_stalls, w_stalls_nxt;
   logic                 r_ovf_st, r_sh_ovf_st, w_ovf_st_nxt, w_stall_ev;

   assign w_stall_ev   = i_count_en & i_stall;
   assign w_stalls_nxt = sat_inc(r_stalls, w_stall_ev);
   assign w_ovf_st_nxt = r_ovf_st | (w_stall_ev & (r_stalls == '1));

   // Live stall counter, same restart rules as beats/packets.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_stalls <= '0;
         r_ovf_st <= 1'b0;
      end else if (i_clear || i_start) begin
         r_stalls <= '0;
         r_ovf_st <= 1'b0;
      end else if (i_snap && i_restart) begin
         r_stalls <= '0;
         r_ovf_st <= w_ovf_st_nxt;
      end else begin
         r_stalls <= w_stalls_nxt;
         r_ovf_st <= w_ovf_st_nxt;
      end
   end

   // Shadow stall count and its overflow bit.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_sh_stalls <= '0;
         r_sh_ovf_st <= 1'b0;
      end else if (i_clear) begin
         r_sh_stalls <= '0;
         r_sh_ovf_st <= 1'b0;
      end else if (i_snap) begin
         r_sh_stalls <= w_stalls_nxt;
         r_sh_ovf_st <= w_ovf_st_nxt;
      end
   end

   assign o_stalls = r_sh_stalls;
   assign o_ovf    = {r_sh_ovf_st, r_sh_ovf};
`else
   assign o_stalls = '0;
   assign o_ovf    = {1'b0, r_sh_ovf};
`endif

endmodule

// File: rtl/stream_perf_monitor.sv
// Passive AXI-Stream throughput monitor: FSM, window counter, global
// shadow registers and registered read mux. Define PERF_MON_STALL_COUNT_EN
// to add per-channel stall counting.
module stream_perf_monitor
   import perf_mon_pkg::*;
#(
   parameter int          NUM_STREAMS   = 4,
   parameter int          CNT_WIDTH     = 32,
   parameter int unsigned WINDOW_CYCLES = 32'h000F_4240,
   parameter int          RD_ADDR_W     = $clog2(NUM_STREAMS*4+2)
) (
   input  logic                   aclk,
   input  logic                   resetn,
   input  logic [NUM_STREAMS-1:0] mon_tvalid,
   input  logic [NUM_STREAMS-1:0] mon_tready,
   input  logic [NUM_STREAMS-1:0] mon_tlast,
   input  logic                   cmd_valid,
   input  logic [1:0]             cmd_op,
   input  logic                   cmd_continuous,
   input  logic [RD_ADDR_W-1:0]   rd_addr,
   output logic [CNT_WIDTH-1:0]   rd_data,
   output logic                   busy,
   output logic                   snap_pulse,
   output logic                   done
);

   // Window position only needs to span the window length.
   localparam int             WIN_W    = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   state_t               r_state, w_state_nxt;
   logic [WIN_W-1:0]     r_win_cnt;
   logic                 r_cont, r_snap;
   logic [CNT_WIDTH-1:0] r_sh_wcnt, r_sh_elapsed, w_rd_mux;
   logic                 w_run, w_start, w_stop, w_clear, w_win_end, w_snap, w_restart;
   logic [NUM_STREAMS-1:0] w_beat, w_pkt;
   logic [CNT_WIDTH-1:0] w_ch_beats  [NUM_STREAMS];
   logic [CNT_WIDTH-1:0] w_ch_pkts   [NUM_STREAMS];
   logic [CNT_WIDTH-1:0] w_ch_stalls [NUM_STREAMS];
   logic [2:0]           w_ch_ovf    [NUM_STREAMS];

   // Elapsed cycles = position + 1, clipped to the counter width.
   function automatic logic [CNT_WIDTH-1:0] sat_elapsed(input logic [WIN_W-1:0] pos);
      logic [63:0] e;
      e = 64'(pos) + 64'd1;
      if ((e >> CNT_WIDTH) != 64'd0) return '1;
      return CNT_WIDTH'(e);
   endfunction

   assign w_run     = (r_state == RUN);
   assign w_clear   = cmd_valid && (cmd_op == OP_CLEAR);
   assign w_start   = cmd_valid && (cmd_op == OP_START) && !w_run;
   assign w_stop    = cmd_valid && (cmd_op == OP_STOP) && w_run;
   assign w_win_end = w_run && (r_win_cnt == WIN_LAST);
   assign w_snap    = !w_clear && (w_win_end || w_stop);
   assign w_restart = r_cont && w_win_end && !w_stop;
   assign w_beat    = mon_tvalid & mon_tready;
   assign w_pkt     = mon_tvalid & mon_tready & mon_tlast;

   // State register.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state: clear dominates, START from IDLE/DONE, STOP or one-shot end from RUN.
   always_comb begin
      w_state_nxt = r_state;
      if (w_clear) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: if (w_start) w_state_nxt = RUN;
            RUN:        if (w_stop || (w_win_end && !r_cont)) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
         endcase
      end
   end

   // Window position, mode latch and snapshot pulse.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_win_cnt <= '0;
         r_cont    <= 1'b0;
         r_snap    <= 1'b0;
      end else begin
         r_snap <= w_snap;
         if (w_clear) begin
            r_win_cnt <= '0;
            r_cont    <= 1'b0;
         end else if (w_start) begin
            r_win_cnt <= '0;
            r_cont    <= cmd_continuous;
         end else if (w_run) begin
            r_win_cnt <= (w_win_end || w_stop) ? '0 : r_win_cnt + 1'b1;
         end
      end
   end

   // Global shadow registers: completed-window count and elapsed cycles.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_sh_wcnt    <= '0;
         r_sh_elapsed <= '0;
      end else if (w_clear) begin
         r_sh_wcnt    <= '0;
         r_sh_elapsed <= '0;
      end else if (w_snap) begin
         r_sh_elapsed <= sat_elapsed(r_win_cnt);
         if (w_win_end && (r_sh_wcnt != '1)) r_sh_wcnt <= r_sh_wcnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_ch
      perf_channel_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .aclk       (aclk),
         .resetn     (resetn),
         .i_beat     (w_beat[g]),
         .i_pkt      (w_pkt[g]),
`ifdef PERF_MON_STALL_COUNT_EN
         .i_stall    (mon_tvalid[g] & ~mon_tready[g]),
`endif
         .i_count_en (w_run && !w_clear),
         .i_start    (w_start && !w_clear),
         .i_clear    (w_clear),
         .i_snap     (w_snap),
         .i_restart  (w_restart),
         .o_beats    (w_ch_beats[g]),
         .o_pkts     (w_ch_pkts[g]),
         .o_stalls   (w_ch_stalls[g]),
         .o_ovf      (w_ch_ovf[g])
      );
   end

   // Read mux over the shadow bank; unmapped addresses read zero.
   always_comb begin
      w_rd_mux = '0;
      for (int c = 0; c < NUM_STREAMS; c++) begin
         if (rd_addr == RD_ADDR_W'(c*STRIDE + OFF_BEATS))  w_rd_mux = w_ch_beats[c];
         if (rd_addr == RD_ADDR_W'(c*STRIDE + OFF_PKTS))   w_rd_mux = w_ch_pkts[c];
         if (rd_addr == RD_ADDR_W'(c*STRIDE + OFF_STALLS)) w_rd_mux = w_ch_stalls[c];
         if (rd_addr == RD_ADDR_W'(c*STRIDE + OFF_OVF))    w_rd_mux = {{(CNT_WIDTH-3){1'b0}}, w_ch_ovf[c]};
      end
      if (rd_addr == RD_ADDR_W'(NUM_STREAMS*STRIDE))     w_rd_mux = r_sh_wcnt;
      if (rd_addr == RD_ADDR_W'(NUM_STREAMS*STRIDE + 1)) w_rd_mux = r_sh_elapsed;
   end

   // Registered read data: one cycle of latency, sees pre-snapshot content.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) rd_data <= '0;
      else         rd_data <= w_rd_mux;
   end

   assign busy       = w_run;
   assign done       = (r_state == DONE);
   assign snap_pulse = r_snap;

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Self-checking bench: randomized traffic against an event-counting model.
module tb_stream_perf_monitor;

   localparam int NS = 4;
   localparam int W  = 100;

   logic        aclk = 1'b0;
   logic        resetn;
   logic [NS-1:0] mon_tvalid, mon_tready, mon_tlast;
   logic        cmd_valid, cmd_continuous;
   logic [1:0]  cmd_op;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        busy, snap_pulse, done;

   logic        m8_v, m8_r, m8_l, c8_valid, c8_cont;
   logic [1:0]  c8_op;
   logic [2:0]  rd8_addr;
   logic [7:0]  rd8_data;
   logic        busy8, snap8, done8;

   int checks = 0;
   int failures = 0;

   // Model state: live (e_) and shadow (s_) views of the counters.
   int unsigned e_beat[NS], e_pkt[NS], e_stall[NS], e_cyc;
   int unsigned s_beat[NS], s_pkt[NS], s_stall[NS], s_wcnt, s_elapsed;
   bit f_ch0, f_ch1, f_ch2, alt;
   int unsigned ch0_n;

   always #5 aclk = ~aclk;

   stream_perf_monitor #(.NUM_STREAMS(NS), .CNT_WIDTH(32), .WINDOW_CYCLES(W)) dut (
      .aclk(aclk), .resetn(resetn), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
      .mon_tlast(mon_tlast), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_continuous(cmd_continuous), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .snap_pulse(snap_pulse), .done(done));

   stream_perf_monitor #(.NUM_STREAMS(1), .CNT_WIDTH(8), .WINDOW_CYCLES(300)) dut8 (
      .aclk(aclk), .resetn(resetn), .mon_tvalid(m8_v), .mon_tready(m8_r),
      .mon_tlast(m8_l), .cmd_valid(c8_valid), .cmd_op(c8_op),
      .cmd_continuous(c8_cont), .rd_addr(rd8_addr), .rd_data(rd8_data),
      .busy(busy8), .snap_pulse(snap8), .done(done8));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic model_zero_live();
      for (int c = 0; c < NS; c++) begin
         e_beat[c] = 0; e_pkt[c] = 0; e_stall[c] = 0;
      end
      e_cyc = 0;
   endtask

   task automatic model_zero_shadow();
      for (int c = 0; c < NS; c++) begin
         s_beat[c] = 0; s_pkt[c] = 0; s_stall[c] = 0;
      end
      s_wcnt = 0; s_elapsed = 0;
   endtask

   task automatic model_snap(input bit full_window);
      for (int c = 0; c < NS; c++) begin
         s_beat[c] = e_beat[c]; s_pkt[c] = e_pkt[c]; s_stall[c] = e_stall[c];
      end
      s_elapsed = e_cyc;
      if (full_window) s_wcnt++;
   endtask

   function automatic logic [63:0] exp_rd(input int a);
      int c;
      c = a / 4;
      if (a < NS*4) begin
         case (a % 4)
            0: return 64'(s_beat[c]);
            1: return 64'(s_pkt[c]);
`ifdef PERF_MON_STALL_COUNT_EN
            2: return 64'(s_stall[c]);
`else
            2: return 64'd0;
`endif
            default: return 64'd0;
         endcase
      end
      if (a == NS*4)   return 64'(s_wcnt);
      if (a == NS*4+1) return 64'(s_elapsed);
      return 64'd0;
   endfunction

   function automatic int addr_of(input int i);
      return (i < NS*4+2) ? i : 31;
   endfunction

   // One bus cycle of random traffic; counted into the model when cnt is set.
   task automatic drive_cycle(input bit cnt);
      logic [NS-1:0] v, r, l;
      v = NS'($urandom); r = NS'($urandom); l = NS'($urandom);
      if (f_ch0) begin v[0] = 1'b1; r[0] = 1'b1; l[0] = (ch0_n % 4 == 3); ch0_n++; end
      if (f_ch1) begin v[1] = alt; r[1] = alt; alt = !alt; end
      if (f_ch2) begin v[2] = 1'b1; r[2] = 1'b0; end
      mon_tvalid = v; mon_tready = r; mon_tlast = l;
      if (cnt) begin
         for (int c = 0; c < NS; c++) begin
            e_beat[c]  += int'(v[c] & r[c]);
            e_pkt[c]   += int'(v[c] & r[c] & l[c]);
            e_stall[c] += int'(v[c] & ~r[c]);
         end
         e_cyc++;
      end
      step();
   endtask

   task automatic issue(input logic [1:0] op, input bit cont, input bit cnt);
      cmd_valid = 1'b1; cmd_op = op; cmd_continuous = cont;
      drive_cycle(cnt);
      cmd_valid = 1'b0;
   endtask

   task automatic read_all(input bit cnt, input string pfx);
      for (int i = 0; i < NS*4+3; i++) begin
         rd_addr = 5'(addr_of(i));
         drive_cycle(cnt);
         check($sformatf("%s_a%0d", pfx, addr_of(i)), 64'(rd_data), exp_rd(addr_of(i)));
      end
   endtask

   task automatic read8(input int a, input logic [63:0] exp, input string tag);
      rd8_addr = 3'(a);
      step();
      check(tag, 64'(rd8_data), exp);
   endtask

   initial begin
      int unsigned pk8, sum1;
      resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_continuous = 1'b0;
      rd_addr = '0; mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
      m8_v = 0; m8_r = 0; m8_l = 0; c8_valid = 0; c8_op = 0; c8_cont = 0; rd8_addr = 0;
      f_ch0 = 0; f_ch1 = 0; f_ch2 = 0; alt = 0; ch0_n = 0;
      model_zero_live(); model_zero_shadow();
      repeat (3) step();
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_snap", 64'(snap_pulse), 0);
      check("rst_rd", 64'(rd_data), 0);
      resetn = 1'b1;
      step();

      // One-shot window with ch0 streaming and tlast every 4th beat.
      f_ch0 = 1; ch0_n = 0;
      issue(2'd0, 1'b0, 1'b0);
      model_zero_live();
      check("os_busy", 64'(busy), 1);
      for (int i = 0; i < W; i++) begin
         check("os_nodone", 64'(done), 0);
         drive_cycle(1'b1);
      end
      model_snap(1'b1);
      check("os_snap", 64'(snap_pulse), 1);
      check("os_done", 64'(done), 1);
      check("os_busy_lo", 64'(busy), 0);
      f_ch0 = 0;
      read_all(1'b0, "os");
      check("os_snap_once", 64'(snap_pulse), 0);
      rd_addr = 5'd0; drive_cycle(1'b0); check("os_beats100", 64'(rd_data), 100);
      rd_addr = 5'd1; drive_cycle(1'b0); check("os_pkts25", 64'(rd_data), 25);

      // Continuous: three back-to-back windows, ch1 alternating.
      issue(2'd2, 1'b0, 1'b0);
      model_zero_live(); model_zero_shadow();
      f_ch1 = 1; alt = 1; sum1 = 0;
      issue(2'd0, 1'b1, 1'b0);
      model_zero_live();
      for (int w = 0; w < 4; w++) begin
         if (w > 0) check($sformatf("ct_snap%0d", w), 64'(snap_pulse), 1);
         for (int i = 0; i < W; i++) begin
            if (w > 0 && i < NS*4+3) rd_addr = 5'(addr_of(i));
            if (w == 3 && i == NS*4+3) begin
               cmd_valid = 1'b1; cmd_op = 2'd1;
            end
            drive_cycle(1'b1);
            cmd_valid = 1'b0;
            if (w > 0 && i < NS*4+3) begin
               check($sformatf("ct_w%0d_a%0d", w, addr_of(i)), 64'(rd_data), exp_rd(addr_of(i)));
               if (addr_of(i) == 4) sum1 += rd_data;
            end
            if (w == 3 && i == NS*4+3) break;
            if (w < 3 && i > 0) check("ct_busy", 64'(busy), 1);
         end
         if (w < 3) begin
            model_snap(1'b1);
            model_zero_live();
         end
      end
      check("ct_sum150", 64'(sum1), 150);
      model_snap(1'b0);
      check("ct_stop_snap", 64'(snap_pulse), 1);
      check("ct_stop_done", 64'(done), 1);
      f_ch1 = 0;
      read_all(1'b0, "ctstop");

      // Reset in the middle of a continuous window.
      issue(2'd0, 1'b1, 1'b0);
      repeat (50) drive_cycle(1'b0);
      resetn = 1'b0;
      #1;
      check("mr_busy", 64'(busy), 0);
      check("mr_rd", 64'(rd_data), 0);
      check("mr_snap", 64'(snap_pulse), 0);
      step();
      resetn = 1'b1;
      model_zero_live(); model_zero_shadow();
      read_all(1'b0, "mr");
      check("mr_busy2", 64'(busy), 0);

      // STOP after 37 cycles with ch2 stalled throughout.
      f_ch2 = 1;
      issue(2'd0, 1'b0, 1'b0);
      model_zero_live();
      repeat (36) drive_cycle(1'b1);
      issue(2'd1, 1'b0, 1'b1);
      model_snap(1'b0);
      check("st_snap", 64'(snap_pulse), 1);
      check("st_done", 64'(done), 1);
      f_ch2 = 0;
      read_all(1'b0, "st");
      issue(2'd1, 1'b0, 1'b0);
      check("st_ignored", 64'(snap_pulse), 0);
      issue(2'd3, 1'b0, 1'b0);
      check("rsv_done", 64'(done), 1);

      // CLEAR landing on the final cycle of a one-shot window.
      issue(2'd0, 1'b0, 1'b0);
      model_zero_live();
      repeat (W-1) drive_cycle(1'b1);
      issue(2'd2, 1'b0, 1'b1);
      model_zero_live(); model_zero_shadow();
      check("cl_snap", 64'(snap_pulse), 0);
      check("cl_busy", 64'(busy), 0);
      check("cl_done", 64'(done), 0);
      read_all(1'b0, "cl");

      // 8-bit counters: 300 beats saturate, overflow sticky until next START.
      c8_valid = 1; c8_op = 2'd0; c8_cont = 0; step(); c8_valid = 0;
      pk8 = 0;
      for (int i = 0; i < 300; i++) begin
         m8_v = 1; m8_r = 1; m8_l = 1'($urandom);
         pk8 += int'(m8_l);
         step();
      end
      m8_v = 0; m8_r = 0;
      check("s8_snap", 64'(snap8), 1);
      check("s8_done", 64'(done8), 1);
      read8(0, 255, "s8_beats");
      read8(1, (pk8 > 255) ? 255 : pk8, "s8_pkts");
      read8(3, 64'(1 | ((pk8 > 255) ? 2 : 0)), "s8_ovf");
      read8(4, 1, "s8_wcnt");
      c8_valid = 1; c8_op = 2'd0; step(); c8_valid = 0;
      m8_v = 1; m8_r = 1; m8_l = 0;
      repeat (4) step();
      c8_valid = 1; c8_op = 2'd1; step(); c8_valid = 0;
      m8_v = 0; m8_r = 0;
      read8(0, 5, "s8_beats2");
      read8(3, 0, "s8_ovf_clr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
